// File: rtl/ram_arbiter.sv
// -----------------------------------------------------------------------------
// ram_arbiter
//
// Shares one single-port data RAM (asynchronous read, synchronous write,
// word-addressed by a[AW-1:2]) between two requesters:
//   port 0 : CPU data side
//   port 1 : debug / loader side
//
// In IDLE, a winning request is picked and its fields are latched. The RAM is
// then driven for exactly one ACCESS cycle, and the requester gets a one-cycle
// ack in RESP. The sequence is IDLE -> ACCESS -> RESP -> IDLE, so there is one
// access every three cycles.
//
// Misaligned addresses and word indices >= DEPTH are flagged through mX_err.
// A flagged access never writes the RAM and returns zero read data.
//
// Build option:
//   RAM_ARB_FIXED_PRIO_EN  defined   : port 0 always wins a tie (port 1 may starve)
//                          undefined : round-robin on ties (default)
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   m0_req/we/addr/wdata       port 0 request (level, held until m0_ack)
//   m0_ack/rdata/err           port 0 response (valid while m0_ack=1)
//   m1_*                       same as m0_*, for port 1
//   ram_a, ram_we, ram_wd      RAM address / write enable / write data
//   ram_rd                     RAM read data (combinational from ram_a)
//   busy                       high in ACCESS and RESP
// -----------------------------------------------------------------------------
module ram_arbiter #(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int DEPTH = 64
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_err,

    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_err,

    output logic [AW-1:0] ram_a,
    output logic          ram_we,
    output logic [DW-1:0] ram_wd,
    input  logic [DW-1:0] ram_rd,

    output logic          busy
);

    // Word index width and the first out-of-range index at that width.
    localparam int             IW        = AW - 2;
    localparam logic [IW-1:0]  DEPTH_IDX = IW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t        state_reg, state_next;
    logic          sel_reg,   sel_next;
    logic          we_reg,    we_next;
    logic [AW-1:0] addr_reg,  addr_next;
    logic [DW-1:0] wdata_reg, wdata_next;
    logic          err_reg,   err_next;
    logic [DW-1:0] rdata_reg, rdata_next;
`ifndef RAM_ARB_FIXED_PRIO_EN
    logic          last_grant_reg, last_grant_next;
`endif

    // Per-port views of the request and response signals.
    logic [1:0]    req_vec;
    logic          we_vec    [2];
    logic [AW-1:0] addr_vec  [2];
    logic [DW-1:0] wdata_vec [2];
    logic          ack_vec   [2];
    logic          err_vec   [2];
    logic [DW-1:0] rdata_vec [2];
    logic          grant;

    assign req_vec      = {m1_req, m0_req};
    assign we_vec[0]    = m0_we;
    assign we_vec[1]    = m1_we;
    assign addr_vec[0]  = m0_addr;
    assign addr_vec[1]  = m1_addr;
    assign wdata_vec[0] = m0_wdata;
    assign wdata_vec[1] = m1_wdata;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            // Only the selected port sees the response; the other stays at 0.
            assign ack_vec[gi]   = (state_reg == RESP) && (sel_reg == 1'(gi));
            assign err_vec[gi]   = ack_vec[gi] && err_reg;
            assign rdata_vec[gi] = ack_vec[gi] ? rdata_reg : '0;
        end
    endgenerate

    assign m0_ack   = ack_vec[0];
    assign m0_err   = err_vec[0];
    assign m0_rdata = rdata_vec[0];
    assign m1_ack   = ack_vec[1];
    assign m1_err   = err_vec[1];
    assign m1_rdata = rdata_vec[1];

    // The latched address and data are only updated on a grant, so they
    // naturally hold their last values outside ACCESS.
    assign ram_a  = addr_reg;
    assign ram_wd = wdata_reg;
    // Decoded from the state, so an asynchronous reset drops it at once.
    assign ram_we = (state_reg == ACCESS) && we_reg && !err_reg;
    assign busy   = (state_reg != IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            sel_reg        <= 1'b0;
            we_reg         <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            err_reg        <= 1'b0;
            rdata_reg      <= '0;
`ifndef RAM_ARB_FIXED_PRIO_EN
            // Port 1 counts as last served, so port 0 wins the first tie.
            last_grant_reg <= 1'b1;
`endif
        end else begin
            state_reg      <= state_next;
            sel_reg        <= sel_next;
            we_reg         <= we_next;
            addr_reg       <= addr_next;
            wdata_reg      <= wdata_next;
            err_reg        <= err_next;
            rdata_reg      <= rdata_next;
`ifndef RAM_ARB_FIXED_PRIO_EN
            last_grant_reg <= last_grant_next;
`endif
        end
    end

    // Arbitration, next-state and latch updates.
    always_comb begin
        // A single requester wins outright. req_vec[1] is that port's index
        // whenever exactly one request is high.
        grant = req_vec[1];
        if (req_vec == 2'b11) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
            grant = 1'b0;
`else
            grant = ~last_grant_reg;
`endif
        end

        state_next      = state_reg;
        sel_next        = sel_reg;
        we_next         = we_reg;
        addr_next       = addr_reg;
        wdata_next      = wdata_reg;
        err_next        = err_reg;
        rdata_next      = rdata_reg;
`ifndef RAM_ARB_FIXED_PRIO_EN
        last_grant_next = last_grant_reg;
`endif

        case (state_reg)
            IDLE: begin
                if (|req_vec) begin
                    sel_next        = grant;
                    we_next         = we_vec[grant];
                    addr_next       = addr_vec[grant];
                    wdata_next      = wdata_vec[grant];
                    err_next        = (addr_vec[grant][1:0] != 2'b00) ||
                                      (addr_vec[grant][AW-1:2] >= DEPTH_IDX);
`ifndef RAM_ARB_FIXED_PRIO_EN
                    last_grant_next = grant;
`endif
                    state_next      = ACCESS;
                end
            end
            ACCESS: begin
                // Writes and flagged accesses return zero read data.
                rdata_next = (we_reg || err_reg) ? '0 : ram_rd;
                state_next = RESP;
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
